// File: rtl/uart_gpio_bridge.sv
// uart_gpio_bridge: UART command bridge between a serial host and a GP port.
// 'W' + GP_BYTES bytes writes GPout and answers 'K'. 'R' answers with a GPin
// snapshot, MSB byte first. Any other command answers '?'.
// Optional feature: define UART_GPIO_PARITY_EN for an even parity bit on RX and TX.
`timescale 1ns/1ps
module uart_gpio_bridge #(
   parameter int CLK_HZ   = 50000000,
   parameter int BAUD     = 115200,
   parameter int GP_BYTES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RxD,
   output logic                  TxD,
   output logic [8*GP_BYTES-1:0] GPout,
   input  logic [8*GP_BYTES-1:0] GPin,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  cmd_err
);
   localparam int GPW  = 8 * GP_BYTES;
   localparam int DIV  = CLK_HZ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam int TOUT = 32 * DIV;
   localparam int TW   = $clog2(TOUT + 2);
   localparam int BCW  = $clog2(GP_BYTES + 1);
`ifdef UART_GPIO_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   // ---------------- RX synchroniser ----------------
   logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic rx_fall;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= RxD;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

   assign rx_fall = rxd_prev_q & ~rxd_sync_q;

   // ---------------- RX frame FSM ----------------
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_par_bad_q, rx_par_bad_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;

   // RX state register; valid/error pulses land one cycle after the stop sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_bad_q <= 1'b0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_bad_q <= rx_par_bad_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // RX next state: start re-check at half a bit, then sample every mid-bit
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_bad_d = rx_par_bad_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == CW'(HALF - 1)) begin
               rx_cnt_d     = '0;
               rx_bit_d     = '0;
               rx_par_bad_d = 1'b0;
               rx_state_d   = rxd_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CW'(DIV - 1)) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) begin
`ifdef UART_GPIO_PARITY_EN
                  rx_state_d = RX_PAR;
`else
                  rx_state_d = RX_STOP;
`endif
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_PAR: begin
            if (rx_cnt_q == CW'(DIV - 1)) begin
               rx_cnt_d     = '0;
               rx_par_bad_d = rxd_sync_q ^ (^rx_shift_q);
               rx_state_d   = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == CW'(DIV - 1)) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               if (rxd_sync_q && !rx_par_bad_q) rx_valid_d  = 1'b1;
               else                             frame_err_d = 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- TX engine ----------------
   logic [FRAME_BITS-1:0] tx_shift_q, tx_frame;
   logic [3:0]            tx_bits_q;
   logic [CW-1:0]         tx_cnt_q;
   logic                  tx_active, tx_last, tx_ready, tx_load;
   logic [7:0]            tx_byte;

   assign tx_active = (tx_bits_q != 4'd0);
   assign tx_last   = tx_active && (tx_cnt_q == CW'(DIV - 1)) && (tx_bits_q == 4'd1);
   // A new byte may load in the last stop-bit cycle so frames run back to back
   assign tx_ready  = !tx_active || tx_last;
   assign TxD       = tx_active ? tx_shift_q[0] : 1'b1;
`ifdef UART_GPIO_PARITY_EN
   assign tx_frame  = {1'b1, ^tx_byte, tx_byte, 1'b0};
`else
   assign tx_frame  = {1'b1, tx_byte, 1'b0};
`endif

   // TX shifter: each frame bit held for exactly DIV clocks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_q <= '0;
         tx_bits_q  <= '0;
         tx_cnt_q   <= '0;
      end else if (tx_load) begin
         tx_shift_q <= tx_frame;
         tx_bits_q  <= 4'(FRAME_BITS);
         tx_cnt_q   <= '0;
      end else if (tx_active) begin
         if (tx_cnt_q == CW'(DIV - 1)) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b1, tx_shift_q[FRAME_BITS-1:1]};
            tx_bits_q  <= tx_bits_q - 1'b1;
         end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
         end
      end
   end

   // ---------------- Command FSM ----------------
   typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RESP} cmd_state_e;
   cmd_state_e     st_q, st_d;
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
   logic [BCW-1:0] resp_cnt_q, resp_cnt_d;
   logic [GPW-1:0] shadow_q, shadow_d;
   logic [GPW-1:0] gpout_q, gpout_d;
   logic [GPW-1:0] resp_buf_q, resp_buf_d;
   logic [TW-1:0]  gap_q, gap_d;
   logic           cmd_err_q, cmd_err_d;

   // Command state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= ST_IDLE;
         byte_cnt_q <= '0;
         resp_cnt_q <= '0;
         shadow_q   <= '0;
         gpout_q    <= '0;
         resp_buf_q <= '0;
         gap_q      <= '0;
         cmd_err_q  <= 1'b0;
      end else begin
         st_q       <= st_d;
         byte_cnt_q <= byte_cnt_d;
         resp_cnt_q <= resp_cnt_d;
         shadow_q   <= shadow_d;
         gpout_q    <= gpout_d;
         resp_buf_q <= resp_buf_d;
         gap_q      <= gap_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   // Command decode; responses are queued MSB byte first in resp_buf
   always_comb begin
      st_d       = st_q;
      byte_cnt_d = byte_cnt_q;
      resp_cnt_d = resp_cnt_q;
      shadow_d   = shadow_q;
      gpout_d    = gpout_q;
      resp_buf_d = resp_buf_q;
      gap_d      = gap_q;
      cmd_err_d  = 1'b0;
      tx_load    = 1'b0;
      tx_byte    = resp_buf_q[GPW-1 -: 8];
      case (st_q)
         ST_IDLE: begin
            if (rx_valid_q) begin
               if (rx_shift_q == 8'h57) begin
                  st_d       = ST_WDATA;
                  byte_cnt_d = '0;
                  gap_d      = '0;
               end else if (rx_shift_q == 8'h52) begin
                  st_d       = ST_RESP;
                  resp_buf_d = GPin;
                  resp_cnt_d = BCW'(GP_BYTES);
               end else begin
                  cmd_err_d  = 1'b1;
                  st_d       = ST_RESP;
                  resp_buf_d = GPW'(8'h3F) << (GPW - 8);
                  resp_cnt_d = BCW'(1);
               end
            end
         end
         ST_WDATA: begin
            if (rx_valid_q) begin
               shadow_d   = GPW'({shadow_q, rx_shift_q});
               byte_cnt_d = byte_cnt_q + 1'b1;
               gap_d      = '0;
               if (byte_cnt_q == BCW'(GP_BYTES - 1)) begin
                  gpout_d    = GPW'({shadow_q, rx_shift_q});
                  st_d       = ST_RESP;
                  resp_buf_d = GPW'(8'h4B) << (GPW - 8);
                  resp_cnt_d = BCW'(1);
               end
            end else if (gap_q == TW'(TOUT)) begin
               st_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rx_valid_q) cmd_err_d = 1'b1;
            if (resp_cnt_q != '0) begin
               if (tx_ready) begin
                  tx_load    = 1'b1;
                  resp_buf_d = GPW'({resp_buf_q, 8'h00});
                  resp_cnt_d = resp_cnt_q - 1'b1;
               end
            end else if (tx_last) begin
               st_d = ST_IDLE;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   assign GPout     = gpout_q;
   assign busy      = (st_q != ST_IDLE);
   assign frame_err = frame_err_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_gpio_bridge.sv
// Bench for uart_gpio_bridge: directed and random command transactions checked
// against a transaction-level model (expected GPout and expected response bytes).
`timescale 1ns/1ps
module tb_uart_gpio_bridge;
   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 100000;
   localparam int DIV    = CLK_HZ / BAUD;
   localparam int GPW    = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           RxD = 1'b1;
   logic           TxD, busy, frame_err, cmd_err;
   logic [GPW-1:0] GPout;
   logic [GPW-1:0] GPin = '0;

   uart_gpio_bridge #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GP_BYTES(2)) dut (
      .clk(clk), .rst_n(rst_n), .RxD(RxD), .TxD(TxD), .GPout(GPout),
      .GPin(GPin), .busy(busy), .frame_err(frame_err), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cmd_err_total = 0;
   int frame_err_total = 0;
   int mon_bad = 0;
   logic [7:0] mon_q[$];
   logic [GPW-1:0] model_gp = '0;

   // pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (cmd_err)   cmd_err_total   <= cmd_err_total + 1;
      if (frame_err) frame_err_total <= frame_err_total + 1;
   end

   // TxD decoder: appends every received byte, counts malformed frames
   initial begin : tx_mon
      logic [7:0] b;
      logic       ok;
      forever begin
         @(negedge TxD);
         repeat (DIV / 2) @(negedge clk);
         ok = (TxD === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = TxD;
         end
`ifdef UART_GPIO_PARITY_EN
         repeat (DIV) @(negedge clk);
         if (TxD !== ^b) ok = 1'b0;
`endif
         repeat (DIV) @(negedge clk);
         if (TxD !== 1'b1) ok = 1'b0;
         mon_q.push_back(b);
         if (!ok) mon_bad = mon_bad + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // bad=1 corrupts the frame: stop bit 0, or the parity bit when parity is on
   task automatic send_frame(input logic [7:0] b, input logic bad);
      RxD = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         repeat (DIV) @(negedge clk);
      end
`ifdef UART_GPIO_PARITY_EN
      RxD = (^b) ^ bad;
      repeat (DIV) @(negedge clk);
      RxD = 1'b1;
`else
      RxD = ~bad;
`endif
      repeat (DIV) @(negedge clk);
      RxD = 1'b1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 * DIV; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // kind: 0 write, 1 read, 2 unknown command, 3 write abandoned by timeout, 4 bad frame
   task automatic run_txn(input int kind, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [GPW-1:0] gpin_v,
                          input logic [GPW-1:0] gpin_after);
      logic [7:0] exp_q[$];
      int  ce0, fe0, mb0, rd0, exp_ce, exp_fe;
      bit  ok;
      exp_q  = {};
      exp_ce = 0;
      exp_fe = 0;
      GPin   = gpin_v;
      ce0 = cmd_err_total;
      fe0 = frame_err_total;
      mb0 = mon_bad;
      rd0 = mon_q.size();
      case (kind)
         0: begin
            send_frame(8'h57, 1'b0);
            send_frame(b1, 1'b0);
            send_frame(b2, 1'b0);
            model_gp = {b1, b2};
            exp_q.push_back(8'h4B);
         end
         1: begin
            send_frame(8'h52, 1'b0);
            exp_q.push_back(gpin_v[15:8]);
            exp_q.push_back(gpin_v[7:0]);
         end
         2: begin
            send_frame(b0, 1'b0);
            exp_ce = 1;
            exp_q.push_back(8'h3F);
         end
         3: begin
            send_frame(8'h57, 1'b0);
            send_frame(b1, 1'b0);
            repeat (40 * DIV) @(negedge clk);
         end
         default: begin
            send_frame(b0, 1'b1);
            exp_fe = 1;
         end
      endcase
      if (exp_q.size() != 0) check("busy_during_resp", 32'(busy), 32'd1);
      GPin = gpin_after;
      wait_idle(ok);
      check("idle_reached", 32'(ok), 32'd1);
      repeat (2 * DIV) @(negedge clk);
      check("tx_byte_count", mon_q.size() - rd0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (rd0 + i < mon_q.size()) check("tx_byte", 32'(mon_q[rd0 + i]), 32'(exp_q[i]));
      check("tx_frame_format", mon_bad - mb0, 0);
      check("gpout", 32'(GPout), 32'(model_gp));
      check("cmd_err_pulses", cmd_err_total - ce0, exp_ce);
      check("frame_err_pulses", frame_err_total - fe0, exp_fe);
      check("busy_low_after", 32'(busy), 32'd0);
      $display("txn kind=%0d b0=%h b1=%h b2=%h gpin=%h gpout=%h tx_bytes=%0d checks=%0d errors=%0d",
               kind, b0, b1, b2, gpin_v, GPout, mon_q.size() - rd0, checks, errors);
   endtask

   initial begin : main
      int kind;
      logic [7:0] r0, r1, r2;
      logic [GPW-1:0] g0, g1;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(TxD), 32'd1);
      check("rst_gpout", 32'(GPout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_cmd_err", 32'(cmd_err), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_txd", 32'(TxD), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);

      // directed transactions
      run_txn(3, 8'h00, 8'h12, 8'h00, 16'h0000, 16'h0000);
      run_txn(1, 8'h00, 8'h00, 8'h00, 16'h3C96, 16'h3C96);
      run_txn(0, 8'h00, 8'h12, 8'h34, 16'h0000, 16'h0000);
      run_txn(1, 8'h00, 8'h00, 8'h00, 16'hA55A, 16'h0000);
      run_txn(2, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000);
      run_txn(4, 8'h57, 8'h00, 8'h00, 16'h0000, 16'h0000);
      run_txn(0, 8'h00, 8'hFF, 8'h00, 16'h0000, 16'h0000);

      // random transactions
      for (int n = 0; n < 10; n++) begin
         kind = int'($urandom_range(0, 4));
         r0 = 8'($urandom_range(0, 255));
         while (r0 == 8'h57 || r0 == 8'h52) r0 = 8'($urandom_range(0, 255));
         r1 = 8'($urandom_range(0, 255));
         r2 = 8'($urandom_range(0, 255));
         g0 = 16'($urandom_range(0, 65535));
         g1 = 16'($urandom_range(0, 65535));
         run_txn(kind, r0, r1, r2, g0, g1);
      end

      // reset in the middle of the 0xA5 response byte (inside data bit 3, a 0)
      GPin = 16'hA55A;
      send_frame(8'h52, 1'b0);
      repeat (4 * DIV + DIV / 2) @(negedge clk);
      check("busy_before_rst", 32'(busy), 32'd1);
      check("txd_low_before_rst", 32'(TxD), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_txd", 32'(TxD), 32'd1);
      check("mid_rst_gpout", 32'(GPout), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      model_gp = '0;
      $display("txn reset during response: txd=%b gpout=%h busy=%b", TxD, GPout, busy);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * DIV) @(negedge clk);
      g0 = 16'($urandom_range(0, 65535));
      run_txn(1, 8'h00, 8'h00, 8'h00, g0, ~g0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
